// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit adder that runs one full-adder cell over the operands, LSB first.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E_WIDTH (one add per WIDTH+2 cycles).
// Backpressure: none; start is only honoured in IDLE, starts during SHIFT/DONE are dropped, not queued.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, a, b, cin request and operands, sampled on the accepting edge only
//   busy            high during the WIDTH bit-processing cycles
//   done            one-cycle pulse; sum/cout (and ovf) valid from this cycle on
//   sum, cout       registered result, updated only at the completing edge or reset
//   ovf             two's-complement overflow, present only when BIT_SERIAL_ADDER_OVF_EN is defined
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] res_full;

  // The single full-adder cell, always looking at the current LSBs and the carry flop.
  assign fa_s = op_a[0] ^ op_b[0] ^ carry;
  assign fa_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  assign last_bit = (cnt == LAST_BIT);

  // Result bits enter from the MSB side, so after WIDTH shifts bit 0 has reached
  // the LSB. On the last shift the full result is the new bit plus the upper bits
  // already collected; it is written to sum directly so sum never ripples.
  assign res_full = {fa_s, res_sh[WIDTH-1:1]};

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand shifters, carry flop, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          res_sh <= res_full;
          if (last_bit) begin
            sum  <= res_full;
            cout <= fa_c;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            // carry is the carry into the MSB, fa_c the carry out of it.
            ovf  <= carry ^ fa_c;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: scoreboard bench for bit_serial_adder at WIDTH=8 and WIDTH=3.
// Expected results come from integer arithmetic on the operands; monitors pop them on done.
// Stimulus is directed cases from the plan plus randomized operands.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start3;
  logic [2:0] a3, b3;
  logic       cin3;
  logic       busy3, done3;
  logic [2:0] sum3;
  logic       cout3;

`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf3;
`endif

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  bit_serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    , .ovf(ovf3)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Expected results: {ovf, cout, sum}.
  logic [9:0] q8[$];
  logic [4:0] q3[$];
  logic [9:0] last8;   // result dut8 should be holding
  int         cyc = 0;
  int         dones3 = 0;
  int         last_done3 = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} for a w-bit unsigned add with carry-in,
  // ovf from the signed interpretation falling outside the w-bit range.
  function automatic int model(input int w, input int a, input int b, input int c);
    int t, half, sa, sb, ss, ov;
    t    = a + b + c;
    half = 1 << (w - 1);
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    ss   = sa + sb + c;
    ov   = (ss > half - 1 || ss < -half) ? 1 : 0;
    return (ov << (w + 1)) | t;
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin : mon8
    logic [9:0] e;
    if (done8) begin
      if (q8.size() == 0) begin
        chk("done8_spurious", 32'(done8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("res8", {23'd0, cout8, sum8}, {23'd0, e[8:0]});
`ifdef BIT_SERIAL_ADDER_OVF_EN
        chk("ovf8", 32'(ovf8), 32'(e[9]));
`endif
      end
    end
  end

  // Monitor for the 3-bit instance, also checking done spacing.
  always @(negedge clk) begin : mon3
    logic [4:0] e;
    if (done3) begin
      dones3++;
      if (last_done3 >= 0) chk("done3_gap", 32'(cyc - last_done3), 32'd5);
      last_done3 = cyc;
      if (q3.size() == 0) begin
        chk("done3_spurious", 32'(done3), 32'd0);
      end else begin
        e = q3.pop_front();
        chk("res3", {28'd0, cout3, sum3}, {28'd0, e[3:0]});
`ifdef BIT_SERIAL_ADDER_OVF_EN
        chk("ovf3", 32'(ovf3), 32'(e[4]));
`endif
      end
    end
  end

  // One add on dut8 from IDLE, with per-cycle busy/done/hold checks.
  // poke pulses start with other operands in the 3rd SHIFT cycle.
  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit poke);
    logic [9:0] e;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    e = 10'(model(8, int'(a), int'(b), int'(c)));
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      chk("busy8_shift", 32'(busy8), 32'd1);
      chk("done8_early", 32'(done8), 32'd0);
      chk("res8_no_ripple", {23'd0, cout8, sum8}, {23'd0, last8[8:0]});
      @(negedge clk);
      start8 = poke && (k == 1);
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    chk("done8_pulse", 32'(done8), 32'd1);
    chk("busy8_in_done", 32'(busy8), 32'd0);
    last8 = e;
    @(negedge clk);
    start8 = 1'b0;
    chk("done8_one_cycle", 32'(done8), 32'd0);
    chk("busy8_idle", 32'(busy8), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    last8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_res8", {23'd0, cout8, sum8}, 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_res3", {28'd0, cout3, sum3}, 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk("rst_ovf8", 32'(ovf8), 32'd0);
`endif

    // Directed cases.
    do8(8'h35, 8'h4A, 1'b0, 1'b0);
    do8(8'hFF, 8'h01, 1'b0, 1'b0);
    do8(8'hFF, 8'hFF, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("res8_hold_idle", {23'd0, cout8, sum8}, {23'd0, last8[8:0]});
    end
    // Start pulsed again during SHIFT must be ignored.
    do8(8'h10, 8'h20, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    // Overflow corners.
    do8(8'h7F, 8'h01, 1'b0, 1'b0);
    do8(8'h80, 8'h80, 1'b0, 1'b0);
    do8(8'hFF, 8'h01, 1'b0, 1'b0);

    // Reset in the 4th SHIFT cycle abandons the add.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1;
    q8.push_back(10'(model(8, 'h55, 'h66, 1)));
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy8_before_reset", 32'(busy8), 32'd1);
    reset = 1'b1;
    q8.delete();
    last8 = '0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy8", 32'(busy8), 32'd0);
    chk("midrst_done8", 32'(done8), 32'd0);
    chk("midrst_res8", {23'd0, cout8, sum8}, 32'd0);
    repeat (12) @(negedge clk);
    do8(8'h01, 8'h01, 1'b0, 1'b0);

    // Randomized back-to-back adds.
    for (int i = 0; i < 24; i++) begin
      do8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    // WIDTH=3 exhaustive with start held high: accepted every 5th cycle.
    for (int n = 0; n < 128 * 5; n++) begin
      @(negedge clk);
      start3 = 1'b1;
      if (n % 5 == 0) begin
        int idx;
        idx = n / 5;
        a3 = 3'(idx & 7); b3 = 3'((idx >> 3) & 7); cin3 = 1'((idx >> 6) & 1);
        q3.push_back(5'(model(3, idx & 7, (idx >> 3) & 7, (idx >> 6) & 1)));
      end else begin
        a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
      end
    end
    @(negedge clk);
    start3 = 1'b0;
    repeat (10) @(negedge clk);
    chk("dones3_count", 32'(dones3), 32'd128);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-bit adder built around a single full-adder cell and a carry flip-flop.
- Processes one bit per clock, LSB first.
- Sits directly downstream of the 1-bit full_adder cell: it sequences that cell over WIDTH bits.
- Start/done handshake toward the controller; registered sum and carry-out toward the consumer.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to add; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while state is SHIFT.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle onward.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out.

Behaviour:
- Reset: on any clk edge with reset=1, state<=IDLE; busy, done, sum, cout, carry, bit counter and shift registers all <=0. This applies mid-operation too: the addition in flight is abandoned and no done is issued.
- FSM states:
  - IDLE: start=1 at edge E0 latches a, b into shift registers, sets carry<=cin, counter<=0, state<=SHIFT. start=0 keeps IDLE.
  - SHIFT: each edge computes s = opA[0]^opB[0]^carry and c = majority(opA[0], opB[0], carry). s is shifted into the result register from the MSB side. opA and opB shift right by 1. carry<=c and counter increments.
  - Completion: at the edge processing bit WIDTH-1 (edge E_WIDTH), sum<=complete result, cout<=c, state<=DONE.
  - DONE: lasts exactly one cycle; done=1. The next edge forces state<=IDLE unconditionally.
- Latency: start sampled at E0, done high in the cycle after E_WIDTH. A new start is therefore accepted at the earliest at E_(WIDTH+2), giving a throughput of one add per WIDTH+2 cycles.
- busy=1 exactly during the WIDTH SHIFT cycles. done and busy are never both high.
- start while busy or done is ignored, with no queuing. a, b and cin may change freely after E0.
- sum and cout change only at the completing edge or at reset. They hold their value through IDLE until the next completion, and do not ripple during SHIFT.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.

Optional Feature:
- Macro: BIT_SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit, registered).
  - At the completing edge, ovf <= (carry into MSB) XOR (carry out of MSB), i.e. two's-complement signed overflow.
  - Reset value 0; updated and held exactly like cout.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start one cycle -> busy high 8 cycles; done pulses once, 8 cycles after the start edge; sum=0x7F, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Results stay stable through the following IDLE cycles.
- WIDTH=3, exhaustive over all 128 (a,b,cin) combinations, back-to-back starts held high -> each result equals a+b+cin split as {cout,sum}. Starts during SHIFT/DONE are ignored, giving exactly one done per 5 cycles.
- WIDTH=8, start with a=0x10, b=0x20; change a/b during SHIFT; pulse start again at cycle 3 -> result 0x30; only one done.
- WIDTH=8, assert reset on 4th SHIFT cycle -> next cycle busy=0, done=0, sum=0x00, cout=0; no done follows. A fresh start (0x01+0x01) then yields 0x02.
- With BIT_SERIAL_ADDER_OVF_EN, WIDTH=8:
  - 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
  - 0x80+0x80 -> sum=0x00, cout=1, ovf=1.
  - 0xFF+0x01 -> ovf=0.
